// File: rtl/onehot_step_sequencer_if.sv
// Control-side bundle between the multiplier control FSM (master) and the step sequencer (slave).
// Carries launch/stall/abort/loop controls in and the registered step decode out.
interface onehot_step_sequencer_if #(
    parameter int NUM_STEPS = 13,
    parameter int IDX_W     = 4
);
    logic                 start;
    logic                 stall;
    logic                 abort;
    logic                 loop_en;
    logic [IDX_W-1:0]     last_step;
    logic                 busy;
    logic [IDX_W-1:0]     step_idx;
    logic [NUM_STEPS-1:0] step_onehot;
    logic                 done;
    logic                 cfg_err;

    modport master (
        output start, stall, abort, loop_en, last_step,
        input  busy, step_idx, step_onehot, done, cfg_err
    );

    modport slave (
        input  start, stall, abort, loop_en, last_step,
        output busy, step_idx, step_onehot, done, cfg_err
    );
endinterface

// File: rtl/onehot_step_sequencer.sv
// Registered step counter with one-hot step-enable decode; step 1 visible one cycle after start.
// Stall holds every output in place; abort returns to idle next cycle without done.
module onehot_step_sequencer #(
    parameter int NUM_STEPS = 13,
    parameter int IDX_W     = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    onehot_step_sequencer_if.slave io_seq
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LP_MAX_IDX = IDX_W'(NUM_STEPS);
    localparam logic [IDX_W-1:0] LP_ONE     = IDX_W'(1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDX_W-1:0]     r_step_idx;
    logic [IDX_W-1:0]     w_step_idx_nxt;
    logic [IDX_W-1:0]     r_last_q;
    logic [IDX_W-1:0]     w_last_q_nxt;
    logic [NUM_STEPS-1:0] r_step_onehot;
    logic [NUM_STEPS-1:0] w_step_onehot_nxt;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 r_cfg_err;
    logic                 w_cfg_err_nxt;
    logic                 w_last_ok;
    logic                 w_at_last;

    assign w_last_ok = (io_seq.last_step != '0) && (io_seq.last_step <= LP_MAX_IDX);
    assign w_at_last = (r_step_idx == r_last_q);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_step_idx    <= '0;
            r_last_q      <= '0;
            r_step_onehot <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_cfg_err     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_step_idx    <= w_step_idx_nxt;
            r_last_q      <= w_last_q_nxt;
            r_step_onehot <= w_step_onehot_nxt;
            r_busy        <= (w_state_nxt == ST_RUN);
            r_done        <= w_done_nxt;
            r_cfg_err     <= w_cfg_err_nxt;
        end
    end

    // Abort outranks stall and start in both states.
    always_comb begin
        w_state_nxt    = r_state;
        w_step_idx_nxt = r_step_idx;
        w_last_q_nxt   = r_last_q;
        w_done_nxt     = 1'b0;
        w_cfg_err_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!io_seq.abort && io_seq.start) begin
                    if (w_last_ok) begin
                        w_state_nxt    = ST_RUN;
                        w_last_q_nxt   = io_seq.last_step;
                        w_step_idx_nxt = LP_ONE;
                    end else begin
                        w_cfg_err_nxt  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (io_seq.abort) begin
                    w_state_nxt    = ST_IDLE;
                    w_step_idx_nxt = '0;
                end else if (!io_seq.stall) begin
                    if (!w_at_last) begin
                        w_step_idx_nxt = r_step_idx + LP_ONE;
                    end else begin
                        w_done_nxt = 1'b1;
                        if (io_seq.loop_en) begin
                            w_step_idx_nxt = LP_ONE;
                        end else begin
                            w_state_nxt    = ST_IDLE;
                            w_step_idx_nxt = '0;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt    = ST_IDLE;
                w_step_idx_nxt = '0;
            end
        endcase
    end

    // Decode the next index so the registered one-hot always matches step_idx.
    always_comb begin
        w_step_onehot_nxt = '0;
        for (int k = 1; k <= NUM_STEPS; k++) begin
            if (w_step_idx_nxt == IDX_W'(k)) begin
                w_step_onehot_nxt[k-1] = 1'b1;
            end
        end
    end

    assign io_seq.busy        = r_busy;
    assign io_seq.step_idx    = r_step_idx;
    assign io_seq.step_onehot = r_step_onehot;
    assign io_seq.done        = r_done;
    assign io_seq.cfg_err     = r_cfg_err;
endmodule

// File: tb/tb_onehot_step_sequencer.sv
// Scoreboard bench: directed vectors push expected post-edge outputs; monitors compare after each edge.
module tb_onehot_step_sequencer;
    logic clk;
    logic rst_a;
    logic rst_b;

    typedef struct {
        logic        busy;
        logic [3:0]  idx;
        logic [15:0] oh;
        logic        done;
        logic        cfg;
        string       name;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb_r;
    int   n_tests;
    int   n_fail;
    int   n_vec;
    string tag;

    onehot_step_sequencer_if #(.NUM_STEPS(13), .IDX_W(4)) ifa();
    onehot_step_sequencer_if #(.NUM_STEPS(5),  .IDX_W(3)) ifb();

    onehot_step_sequencer #(.NUM_STEPS(13), .IDX_W(4)) u_dut_a (
        .i_clk (clk),
        .i_rst (rst_a),
        .io_seq(ifa)
    );

    onehot_step_sequencer #(.NUM_STEPS(5), .IDX_W(3)) u_dut_b (
        .i_clk (clk),
        .i_rst (rst_b),
        .io_seq(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_one(input exp_t e, input logic b, input logic [3:0] i,
                             input logic [15:0] oh, input logic d, input logic c);
        n_tests++;
        if (b !== e.busy || i !== e.idx || oh !== e.oh || d !== e.done || c !== e.cfg) begin
            n_fail++;
            $display("FAIL %s: got busy=%0b idx=%0d onehot=%h done=%0b cfg_err=%0b, want busy=%0b idx=%0d onehot=%h done=%0b cfg_err=%0b",
                     e.name, b, i, oh, d, c, e.busy, e.idx, e.oh, e.done, e.cfg);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (qa.size() != 0) begin
            ea = qa.pop_front();
            check_one(ea, ifa.busy, ifa.step_idx, 16'(ifa.step_onehot), ifa.done, ifa.cfg_err);
        end
    end

    always @(posedge clk) begin
        #1;
        if (qb.size() != 0) begin
            eb_r = qb.pop_front();
            check_one(eb_r, ifb.busy, {1'b0, ifb.step_idx}, 16'(ifb.step_onehot), ifb.done, ifb.cfg_err);
        end
    end

    // Apply one vector before the next edge and queue the outputs expected right after it.
    task automatic cyc(input int tgt, input logic rs, input logic st, input logic sl,
                       input logic ab, input logic lp, input logic [3:0] last,
                       input logic xb, input logic [3:0] xi, input logic xd, input logic xc);
        exp_t e;
        @(negedge clk);
        if (tgt == 0) begin
            rst_a = rs; ifa.start = st; ifa.stall = sl; ifa.abort = ab;
            ifa.loop_en = lp; ifa.last_step = last;
        end else begin
            rst_b = rs; ifb.start = st; ifb.stall = sl; ifb.abort = ab;
            ifb.loop_en = lp; ifb.last_step = last[2:0];
        end
        e.busy = xb;
        e.idx  = xi;
        e.oh   = (xi == 4'd0) ? 16'h0000 : (16'h0001 << (xi - 4'd1));
        e.done = xd;
        e.cfg  = xc;
        e.name = $sformatf("%s#%0d", tag, n_vec);
        n_vec++;
        if (tgt == 0) qa.push_back(e);
        else          qb.push_back(e);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; n_vec = 0;
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.start = 0; ifa.stall = 0; ifa.abort = 0; ifa.loop_en = 0; ifa.last_step = '0;
        ifb.start = 0; ifb.stall = 0; ifb.abort = 0; ifb.loop_en = 0; ifb.last_step = '0;

        tag = "reset";
        cyc(0, 1,0,0,0,0, 4'd0,  0, 4'd0, 0, 0);
        cyc(0, 0,0,0,0,0, 4'd0,  0, 4'd0, 0, 0);

        tag = "full13";
        cyc(0, 0,1,0,0,0, 4'd13, 1, 4'd1, 0, 0);
        for (int k = 2; k <= 13; k++) cyc(0, 0,0,0,0,0, 4'd0, 1, 4'(k), 0, 0);
        cyc(0, 0,0,0,0,0, 4'd0,  0, 4'd0, 1, 0);

        tag = "b2b";
        cyc(0, 0,1,0,0,0, 4'd2,  1, 4'd1, 0, 0);
        cyc(0, 0,0,0,0,0, 4'd0,  1, 4'd2, 0, 0);
        cyc(0, 0,0,0,0,0, 4'd0,  0, 4'd0, 1, 0);
        cyc(0, 0,0,0,0,0, 4'd0,  0, 4'd0, 0, 0);

        tag = "stall";
        cyc(0, 0,1,0,0,0, 4'd4,  1, 4'd1, 0, 0);
        cyc(0, 0,0,0,0,0, 4'd0,  1, 4'd2, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 0,0,1,0,0, 4'd0, 1, 4'd2, 0, 0);
        cyc(0, 0,0,0,0,0, 4'd0,  1, 4'd3, 0, 0);
        cyc(0, 0,0,0,0,0, 4'd0,  1, 4'd4, 0, 0);
        cyc(0, 0,0,0,0,0, 4'd0,  0, 4'd0, 1, 0);
        cyc(0, 0,0,0,0,0, 4'd0,  0, 4'd0, 0, 0);

        tag = "stall_last";
        cyc(0, 0,1,0,0,0, 4'd2,  1, 4'd1, 0, 0);
        cyc(0, 0,0,0,0,0, 4'd0,  1, 4'd2, 0, 0);
        cyc(0, 0,0,1,0,0, 4'd0,  1, 4'd2, 0, 0);
        cyc(0, 0,0,1,0,0, 4'd0,  1, 4'd2, 0, 0);
        cyc(0, 0,0,0,0,0, 4'd0,  0, 4'd0, 1, 0);

        tag = "loop";
        cyc(0, 0,1,0,0,1, 4'd3,  1, 4'd1, 0, 0);
        cyc(0, 0,0,0,0,1, 4'd0,  1, 4'd2, 0, 0);
        cyc(0, 0,0,0,0,1, 4'd0,  1, 4'd3, 0, 0);
        cyc(0, 0,0,0,0,1, 4'd0,  1, 4'd1, 1, 0);
        cyc(0, 0,0,0,0,1, 4'd0,  1, 4'd2, 0, 0);
        cyc(0, 0,0,0,0,1, 4'd0,  1, 4'd3, 0, 0);
        cyc(0, 0,0,0,0,1, 4'd0,  1, 4'd1, 1, 0);
        cyc(0, 0,0,0,0,1, 4'd0,  1, 4'd2, 0, 0);
        cyc(0, 0,0,0,0,0, 4'd0,  1, 4'd3, 0, 0);
        cyc(0, 0,0,0,0,0, 4'd0,  0, 4'd0, 1, 0);
        cyc(0, 0,0,0,0,0, 4'd0,  0, 4'd0, 0, 0);

        tag = "last1";
        cyc(0, 0,1,0,0,0, 4'd1,  1, 4'd1, 0, 0);
        cyc(0, 0,0,0,0,0, 4'd0,  0, 4'd0, 1, 0);
        cyc(0, 0,1,0,0,1, 4'd1,  1, 4'd1, 0, 0);
        cyc(0, 0,0,0,0,1, 4'd0,  1, 4'd1, 1, 0);
        cyc(0, 0,0,0,0,1, 4'd0,  1, 4'd1, 1, 0);
        cyc(0, 0,0,0,0,0, 4'd0,  0, 4'd0, 1, 0);
        cyc(0, 0,0,0,0,0, 4'd0,  0, 4'd0, 0, 0);

        tag = "abort";
        cyc(0, 0,1,0,0,0, 4'd13, 1, 4'd1, 0, 0);
        for (int k = 2; k <= 5; k++) cyc(0, 0,0,0,0,0, 4'd0, 1, 4'(k), 0, 0);
        cyc(0, 0,0,0,1,0, 4'd0,  0, 4'd0, 0, 0);
        cyc(0, 0,1,0,0,0, 4'd13, 1, 4'd1, 0, 0);
        cyc(0, 0,0,0,0,0, 4'd0,  1, 4'd2, 0, 0);
        cyc(0, 0,1,0,1,0, 4'd13, 0, 4'd0, 0, 0);
        cyc(0, 0,1,0,0,0, 4'd13, 1, 4'd1, 0, 0);
        cyc(0, 0,0,1,1,0, 4'd0,  0, 4'd0, 0, 0);
        cyc(0, 0,0,0,0,0, 4'd0,  0, 4'd0, 0, 0);

        tag = "cfg";
        cyc(0, 0,1,0,0,0, 4'd0,  0, 4'd0, 0, 1);
        cyc(0, 0,0,0,0,0, 4'd0,  0, 4'd0, 0, 0);
        cyc(0, 0,1,0,0,0, 4'd14, 0, 4'd0, 0, 1);
        cyc(0, 0,1,0,0,0, 4'd15, 0, 4'd0, 0, 1);
        cyc(0, 0,0,0,0,0, 4'd0,  0, 4'd0, 0, 0);
        cyc(0, 0,1,0,0,0, 4'd13, 1, 4'd1, 0, 0);
        cyc(0, 0,0,0,1,0, 4'd0,  0, 4'd0, 0, 0);

        tag = "start_in_run";
        cyc(0, 0,1,0,0,0, 4'd3,  1, 4'd1, 0, 0);
        cyc(0, 0,1,0,0,0, 4'd13, 1, 4'd2, 0, 0);
        cyc(0, 0,1,0,0,0, 4'd13, 1, 4'd3, 0, 0);
        cyc(0, 0,0,0,0,0, 4'd0,  0, 4'd0, 1, 0);
        cyc(0, 0,0,0,0,0, 4'd0,  0, 4'd0, 0, 0);

        tag = "rst_mid";
        cyc(0, 0,1,0,0,0, 4'd13, 1, 4'd1, 0, 0);
        for (int k = 2; k <= 7; k++) cyc(0, 0,0,0,0,0, 4'd0, 1, 4'(k), 0, 0);
        cyc(0, 1,0,0,0,0, 4'd0,  0, 4'd0, 0, 0);
        cyc(0, 0,0,0,0,0, 4'd0,  0, 4'd0, 0, 0);

        tag = "p5";
        cyc(1, 1,0,0,0,0, 4'd0,  0, 4'd0, 0, 0);
        cyc(1, 0,1,0,0,0, 4'd5,  1, 4'd1, 0, 0);
        for (int k = 2; k <= 5; k++) cyc(1, 0,0,0,0,0, 4'd0, 1, 4'(k), 0, 0);
        cyc(1, 0,0,0,0,0, 4'd0,  0, 4'd0, 1, 0);
        cyc(1, 0,1,0,0,0, 4'd6,  0, 4'd0, 0, 1);
        cyc(1, 0,1,0,0,0, 4'd0,  0, 4'd0, 0, 1);
        cyc(1, 0,0,0,0,0, 4'd0,  0, 4'd0, 0, 0);

        repeat (3) @(negedge clk);
        n_tests++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d expectations left unchecked, want 0/0", qa.size(), qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
